// File: rtl/mem_req_ctrl.sv
// Request FIFO feeding a single-outstanding memory command FSM with registered strobes.
// Optional read watchdog enabled by defining MEM_REQ_CTRL_TIMEOUT_EN.
module mem_req_ctrl #(
  parameter int Data_Width     = 32,
  parameter int Address_Width  = 5,
  parameter int FIFO_Depth     = 4,
  parameter int Timeout_Cycles = 15
) (
  input  logic                          CLK,
  input  logic                          Rst_n,
  input  logic                          Req_Valid,
  output logic                          Req_Ready,
  input  logic                          Req_Wr,
  input  logic [Address_Width-1:0]      Req_Addr,
  input  logic [Data_Width-1:0]         Req_Data,
  output logic                          Rsp_Valid,
  input  logic                          Rsp_Ready,
  output logic [Data_Width-1:0]         Rsp_Data,
  output logic [Address_Width-1:0]      Rsp_Addr,
  output logic                          Rsp_Err,
  output logic                          Mem_Wr_En,
  output logic                          Mem_Rd_En,
  output logic [Address_Width-1:0]      Mem_Address,
  output logic [Data_Width-1:0]         Mem_Data_in,
  input  logic [Data_Width-1:0]         Mem_Data_out,
  input  logic                          Mem_Valid_out,
  output logic [$clog2(FIFO_Depth):0]   Fifo_Count
);

  localparam int Ptr_W = $clog2(FIFO_Depth);
  localparam int Cnt_W = Ptr_W + 1;

  if (FIFO_Depth < 2 || (FIFO_Depth & (FIFO_Depth - 1)) != 0 || Timeout_Cycles < 1) begin : g_bad_cfg
    $error("mem_req_ctrl: FIFO_Depth must be a power of two >= 2 and Timeout_Cycles >= 1");
  end

  typedef struct packed {
    logic                     wr;
    logic [Address_Width-1:0] addr;
    logic [Data_Width-1:0]    data;
  } cmd_t;

  typedef enum logic [2:0] {IDLE, WRITE, READ, WAIT, RESP} state_t;

  cmd_t               r_fifo_mem [FIFO_Depth];
  logic [Ptr_W-1:0]   r_wr_ptr;
  logic [Ptr_W-1:0]   r_rd_ptr;
  logic [Cnt_W-1:0]   r_count;

  state_t             r_state;
  state_t             w_next;

  logic               w_full;
  logic               w_push;
  logic               w_pop;
  logic               w_rsp_load;
  logic               w_rsp_timeout;
  cmd_t               w_head;

  logic                     r_wr_en;
  logic                     r_rd_en;
  logic [Address_Width-1:0] r_addr;
  logic [Data_Width-1:0]    r_wdata;
  logic                     r_rsp_valid;
  logic [Data_Width-1:0]    r_rsp_data;
  logic [Address_Width-1:0] r_rsp_addr;

`ifdef MEM_REQ_CTRL_TIMEOUT_EN
  localparam int Wd_W = $clog2(Timeout_Cycles + 1);
  logic [Wd_W-1:0]    r_wd;
  logic               r_rsp_err;
`endif

  // Ready depends on occupancy alone so upstream may gate Valid on Ready.
  assign w_full     = (r_count == Cnt_W'(FIFO_Depth));
  assign Req_Ready  = !w_full;
  assign w_push     = Req_Valid && !w_full;
  assign w_head     = r_fifo_mem[r_rd_ptr];
  assign Fifo_Count = r_count;

  // NOTE: FIFO storage is deliberately not reset; pointers and count alone define which entries are valid.
  always_ff @(posedge CLK) begin
    if (w_push) begin
      r_fifo_mem[r_wr_ptr] <= '{wr: Req_Wr, addr: Req_Addr, data: Req_Data};
    end
  end

  // NOTE: every clocked block uses non-blocking assignments so all flops sample pre-edge values.
  always_ff @(posedge CLK or negedge Rst_n) begin
    if (!Rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge Rst_n) begin
    if (!Rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  // NOTE: defaults assigned first so every path drives every signal and no latch is inferred.
  always_comb begin
    w_next        = r_state;
    w_pop         = 1'b0;
    w_rsp_load    = 1'b0;
    w_rsp_timeout = 1'b0;
    case (r_state)
      IDLE: begin
        if (r_count != '0) begin
          w_pop  = 1'b1;
          w_next = w_head.wr ? WRITE : READ;
        end
      end
      WRITE: w_next = IDLE;
      READ:  w_next = WAIT;
      WAIT: begin
        if (Mem_Valid_out) begin
          w_rsp_load = 1'b1;
          w_next     = RESP;
        end
`ifdef MEM_REQ_CTRL_TIMEOUT_EN
        else if (r_wd == Wd_W'(Timeout_Cycles - 1)) begin
          w_rsp_timeout = 1'b1;
          w_next        = RESP;
        end
`endif
      end
      RESP: begin
        if (Rsp_Ready) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  // Strobes are decoded from the next state so they rise on the same edge the FSM enters WRITE/READ.
  always_ff @(posedge CLK or negedge Rst_n) begin
    if (!Rst_n) begin
      r_wr_en     <= 1'b0;
      r_rd_en     <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= '0;
      r_rsp_addr  <= '0;
    end else begin
      r_wr_en     <= (w_next == WRITE);
      r_rd_en     <= (w_next == READ);
      r_rsp_valid <= (w_next == RESP);
      if (w_pop) begin
        r_addr  <= w_head.addr;
        r_wdata <= w_head.data;
      end
      if (w_rsp_load) begin
        r_rsp_data <= Mem_Data_out;
        r_rsp_addr <= r_addr;
      end else if (w_rsp_timeout) begin
        r_rsp_data <= '0;
        r_rsp_addr <= r_addr;
      end
    end
  end

`ifdef MEM_REQ_CTRL_TIMEOUT_EN
  always_ff @(posedge CLK or negedge Rst_n) begin
    if (!Rst_n) begin
      r_wd      <= '0;
      r_rsp_err <= 1'b0;
    end else begin
      r_wd <= (r_state == WAIT && w_next == WAIT) ? r_wd + 1'b1 : '0;
      if (w_rsp_load)         r_rsp_err <= 1'b0;
      else if (w_rsp_timeout) r_rsp_err <= 1'b1;
    end
  end
  assign Rsp_Err = r_rsp_err;
`else
  assign Rsp_Err = 1'b0;
`endif

  assign Mem_Wr_En   = r_wr_en;
  assign Mem_Rd_En   = r_rd_en;
  assign Mem_Address = r_addr;
  assign Mem_Data_in = r_wdata;
  assign Rsp_Valid   = r_rsp_valid;
  assign Rsp_Data    = r_rsp_data;
  assign Rsp_Addr    = r_rsp_addr;

endmodule

// File: tb/tb_mem_req_ctrl.sv
// Self-checking bench for mem_req_ctrl: directed vector table, multi-cycle corner sequences,
// and a random mixed stream checked against a per-address reference memory.
module tb_mem_req_ctrl;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int FD = 4;
  localparam int TO = 15;

  logic                 CLK = 1'b0;
  logic                 Rst_n;
  logic                 Req_Valid;
  logic                 Req_Ready;
  logic                 Req_Wr;
  logic [AW-1:0]        Req_Addr;
  logic [DW-1:0]        Req_Data;
  logic                 Rsp_Valid;
  logic                 Rsp_Ready;
  logic [DW-1:0]        Rsp_Data;
  logic [AW-1:0]        Rsp_Addr;
  logic                 Rsp_Err;
  logic                 Mem_Wr_En;
  logic                 Mem_Rd_En;
  logic [AW-1:0]        Mem_Address;
  logic [DW-1:0]        Mem_Data_in;
  logic [DW-1:0]        Mem_Data_out;
  logic                 Mem_Valid_out;
  logic [$clog2(FD):0]  Fifo_Count;

  mem_req_ctrl #(
    .Data_Width(DW), .Address_Width(AW), .FIFO_Depth(FD), .Timeout_Cycles(TO)
  ) dut (
    .CLK(CLK), .Rst_n(Rst_n),
    .Req_Valid(Req_Valid), .Req_Ready(Req_Ready), .Req_Wr(Req_Wr),
    .Req_Addr(Req_Addr), .Req_Data(Req_Data),
    .Rsp_Valid(Rsp_Valid), .Rsp_Ready(Rsp_Ready), .Rsp_Data(Rsp_Data),
    .Rsp_Addr(Rsp_Addr), .Rsp_Err(Rsp_Err),
    .Mem_Wr_En(Mem_Wr_En), .Mem_Rd_En(Mem_Rd_En), .Mem_Address(Mem_Address),
    .Mem_Data_in(Mem_Data_in), .Mem_Data_out(Mem_Data_out),
    .Mem_Valid_out(Mem_Valid_out), .Fifo_Count(Fifo_Count)
  );

  always #5 CLK = ~CLK;

  int n_cmp  = 0;
  int n_bad  = 0;
  int cyc    = 0;
  int n_wr   = 0;
  int n_rd   = 0;
  int n_both = 0;

  bit mem_respond   = 1'b1;
  bit force_valid   = 1'b0;
  bit rsp_rand      = 1'b0;
  bit rsp_ready_ctl = 1'b1;

  logic [DW-1:0] mem [1<<AW];

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    int            cyc;
  } wlog_t;

  typedef struct {
    logic [DW-1:0] data;
    logic [AW-1:0] addr;
    logic          err;
  } rsp_t;

  typedef struct {
    logic          wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic [DW-1:0] exp;
  } vec_t;

  wlog_t wlog[$];
  rsp_t  rsp_q[$];

  always @(posedge CLK) cyc++;

  // Memory model and bus monitor: sample mid-cycle, answer a read strobe one cycle later.
  always begin : p_mem
    logic          rd;
    logic [AW-1:0] a;
    @(negedge CLK);
    rd = Mem_Rd_En;
    a  = Mem_Address;
    if (Mem_Wr_En) begin
      mem[Mem_Address] = Mem_Data_in;
      n_wr++;
      wlog.push_back('{Mem_Address, Mem_Data_in, cyc});
    end
    if (Mem_Rd_En) n_rd++;
    if (Mem_Wr_En && Mem_Rd_En) n_both++;
    if (Rsp_Valid && Rsp_Ready) rsp_q.push_back('{Rsp_Data, Rsp_Addr, Rsp_Err});
    @(posedge CLK);
    #2;
    Mem_Valid_out = (rd && mem_respond) || force_valid;
    Mem_Data_out  = force_valid ? 32'h5555_AAAA : (Mem_Valid_out ? mem[a] : 32'hBAD0_0BAD);
    Rsp_Ready     = rsp_rand ? ($urandom_range(0, 1) != 0) : rsp_ready_ctl;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic push(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
    bit rdy;
    rdy       = 1'b0;
    Req_Valid = 1'b1;
    Req_Wr    = wr;
    Req_Addr  = a;
    Req_Data  = d;
    for (int i = 0; i < 300 && !rdy; i++) begin
      @(negedge CLK);
      rdy = Req_Ready;
      step();
    end
    Req_Valid = 1'b0;
    check("push_accepted", rdy, 1);
  endtask

  task automatic wait_rsp(input int n);
    for (int k = 0; k < 300 && rsp_q.size() < n; k++) step();
    check("rsp_arrived", rsp_q.size() >= n, 1);
  endtask

  task automatic wait_wlog(input int n);
    for (int k = 0; k < 100 && wlog.size() < n; k++) step();
    check("write_issued", wlog.size() >= n, 1);
  endtask

  initial begin : main
    vec_t          vecs[11];
    logic [DW-1:0] ref_mem [1<<AW];
    rsp_t          exp_q[$];
    int            nw, nr, exp_rsp, wr_before, rd_before;
    logic          wr;
    logic [AW-1:0] a;
    logic [DW-1:0] d;

    vecs[0]  = '{1'b1, 5'd3,  32'hDEAD_BEEF, 32'h0};
    vecs[1]  = '{1'b0, 5'd3,  32'h0,         32'hDEAD_BEEF};
    vecs[2]  = '{1'b1, 5'd7,  32'h1234_5678, 32'h0};
    vecs[3]  = '{1'b1, 5'd0,  32'hFFFF_FFFF, 32'h0};
    vecs[4]  = '{1'b1, 5'd31, 32'hA5A5_A5A5, 32'h0};
    vecs[5]  = '{1'b0, 5'd31, 32'h0,         32'hA5A5_A5A5};
    vecs[6]  = '{1'b0, 5'd0,  32'h0,         32'hFFFF_FFFF};
    vecs[7]  = '{1'b1, 5'd3,  32'h0000_0001, 32'h0};
    vecs[8]  = '{1'b0, 5'd3,  32'h0,         32'h0000_0001};
    vecs[9]  = '{1'b0, 5'd7,  32'h0,         32'h1234_5678};
    vecs[10] = '{1'b0, 5'd12, 32'h0,         32'h0};

    for (int i = 0; i < (1<<AW); i++) mem[i] = '0;
    Rst_n = 1'b0; Req_Valid = 1'b0; Req_Wr = 1'b0; Req_Addr = '0; Req_Data = '0;
    Rsp_Ready = 1'b1; Mem_Valid_out = 1'b0; Mem_Data_out = '0;

    #2;
    check("rst_req_ready", Req_Ready, 1);
    check("rst_fifo_count", Fifo_Count, 0);
    check("rst_wr_en", Mem_Wr_En, 0);
    check("rst_rd_en", Mem_Rd_En, 0);
    check("rst_rsp_valid", Rsp_Valid, 0);
    step(); step();
    Rst_n = 1'b1;
    step();

    // Directed vector table.
    exp_rsp = 0;
    for (int i = 0; i < 11; i++) begin
      nw = wlog.size();
      nr = rsp_q.size();
      push(vecs[i].wr, vecs[i].addr, vecs[i].data);
      if (vecs[i].wr) begin
        wait_wlog(nw + 1);
        check($sformatf("v%0d_wr_addr", i), wlog[nw].addr, vecs[i].addr);
        check($sformatf("v%0d_wr_data", i), wlog[nw].data, vecs[i].data);
      end else begin
        exp_rsp++;
        wait_rsp(nr + 1);
        check($sformatf("v%0d_rsp_data", i), rsp_q[nr].data, vecs[i].exp);
        check($sformatf("v%0d_rsp_addr", i), rsp_q[nr].addr, vecs[i].addr);
        check($sformatf("v%0d_rsp_err", i), rsp_q[nr].err, 0);
      end
    end
    repeat (4) step();
    check("rsp_count_reads_only", rsp_q.size(), exp_rsp);

    // Strobe latency and width for a single write then a single read.
    push(1'b1, 5'd20, 32'hCAFE_0001);
    @(negedge CLK); check("wr_lat_k0", Mem_Wr_En, 0);
    @(negedge CLK); check("wr_lat_k1", Mem_Wr_En, 1);
    check("wr_lat_addr", Mem_Address, 20);
    check("wr_lat_data", Mem_Data_in, 32'hCAFE_0001);
    check("wr_lat_no_rd", Mem_Rd_En, 0);
    @(negedge CLK); check("wr_lat_k2", Mem_Wr_En, 0);
    step();
    nr = rsp_q.size();
    push(1'b0, 5'd20, 32'h0);
    @(negedge CLK); check("rd_lat_k0", Mem_Rd_En, 0);
    @(negedge CLK); check("rd_lat_k1", Mem_Rd_En, 1);
    check("rd_lat_addr", Mem_Address, 20);
    @(negedge CLK); check("rd_lat_k2", Mem_Rd_En, 0);
    step();
    wait_rsp(nr + 1);
    check("rd_lat_data", rsp_q[nr].data, 32'hCAFE_0001);

    // Held response, FIFO fill to full, fifth request stalls until the response drains.
    rsp_q.delete();
    wlog.delete();
    rsp_ready_ctl = 1'b0;
    step();
    push(1'b0, 5'd7, 32'h0);
    for (int k = 0; k < 50 && !Rsp_Valid; k++) step();
    check("r7_valid", Rsp_Valid, 1);
    wr_before = n_wr;
    for (int i = 0; i < 4; i++) begin
      push(1'b1, 5'(10 + i), 32'h1000_0000 + i);
      @(negedge CLK);
      check($sformatf("fill_count_%0d", i), Fifo_Count, i + 1);
      check($sformatf("fill_ready_%0d", i), Req_Ready, (i < 3));
      check($sformatf("hold_valid_%0d", i), Rsp_Valid, 1);
      check($sformatf("hold_data_%0d", i), Rsp_Data, 32'h1234_5678);
      check($sformatf("hold_addr_%0d", i), Rsp_Addr, 7);
      step();
    end
    for (int j = 0; j < 2; j++) begin
      @(negedge CLK);
      check("hold_valid_tail", Rsp_Valid, 1);
      check("hold_data_tail", Rsp_Data, 32'h1234_5678);
      check("full_ready_low", Req_Ready, 0);
      step();
    end
    check("no_issue_while_resp", n_wr, wr_before);
    fork
      push(1'b1, 5'd14, 32'h1000_0004);
      begin
        @(negedge CLK);
        check("fifth_held", Req_Ready, 0);
        rsp_ready_ctl = 1'b1;
      end
    join
    wait_wlog(5);
    wait_rsp(1);
    check("r7_rsp_data", rsp_q[0].data, 32'h1234_5678);
    check("r7_rsp_addr", rsp_q[0].addr, 7);
    for (int i = 0; i < 5; i++) begin
      check($sformatf("order_addr_%0d", i), wlog[i].addr, 10 + i);
      check($sformatf("order_data_%0d", i), wlog[i].data, 32'h1000_0000 + i);
      if (i > 0) check($sformatf("spacing_%0d", i), wlog[i].cyc - wlog[i-1].cyc, 2);
    end

    // Read to an unresponsive memory.
    rsp_q.delete();
    mem_respond   = 1'b0;
    rsp_ready_ctl = 1'b0;
    step();
    push(1'b0, 5'd9, 32'h0);
    for (int i = 0; i < 18; i++) begin
      @(negedge CLK);
`ifdef MEM_REQ_CTRL_TIMEOUT_EN
      check($sformatf("to_valid_%0d", i), Rsp_Valid, (i == 17));
`else
      check($sformatf("wait_no_valid_%0d", i), Rsp_Valid, 0);
`endif
    end
`ifdef MEM_REQ_CTRL_TIMEOUT_EN
    check("to_err", Rsp_Err, 1);
    check("to_data", Rsp_Data, 0);
    check("to_addr", Rsp_Addr, 9);
    step();
    rsp_ready_ctl = 1'b1;
    for (int k = 0; k < 20 && Rsp_Valid; k++) step();
    check("to_drained", Rsp_Valid, 0);
    rsp_ready_ctl = 1'b0;
    push(1'b0, 5'd9, 32'h0);
    repeat (4) step();
`else
    for (int i = 0; i < 10; i++) begin
      @(negedge CLK);
      check("wait_persist_valid", Rsp_Valid, 0);
      check("wait_persist_rd", Mem_Rd_En, 0);
    end
    step();
`endif

    // Reset in WAIT with two requests queued; a late memory valid must be ignored.
    push(1'b1, 5'd21, 32'hAAAA_0001);
    push(1'b1, 5'd22, 32'hAAAA_0002);
    @(negedge CLK);
    check("q2_count", Fifo_Count, 2);
    check("q2_addr_pre", Mem_Address, 9);
    wr_before = n_wr;
    rd_before = n_rd;
    #2 Rst_n = 1'b0;
    #1;
    check("mid_rst_wr_en", Mem_Wr_En, 0);
    check("mid_rst_rd_en", Mem_Rd_En, 0);
    check("mid_rst_addr", Mem_Address, 0);
    check("mid_rst_wdata", Mem_Data_in, 0);
    check("mid_rst_rsp_valid", Rsp_Valid, 0);
    check("mid_rst_rsp_data", Rsp_Data, 0);
    check("mid_rst_rsp_addr", Rsp_Addr, 0);
    check("mid_rst_rsp_err", Rsp_Err, 0);
    check("mid_rst_count", Fifo_Count, 0);
    check("mid_rst_ready", Req_Ready, 1);
    step();
    Rst_n = 1'b1;
    force_valid = 1'b1;
    step();
    force_valid = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge CLK);
      check("late_valid_no_rsp", Rsp_Valid, 0);
      check("post_rst_count", Fifo_Count, 0);
    end
    check("dropped_writes", n_wr, wr_before);
    check("dropped_reads", n_rd, rd_before);
    mem_respond   = 1'b1;
    rsp_ready_ctl = 1'b1;
    step();

    // Random mixed stream against a per-address reference.
    rsp_q.delete();
    for (int i = 0; i < (1<<AW); i++) begin
      d = $urandom;
      push(1'b1, 5'(i), d);
      ref_mem[i] = d;
    end
    rsp_rand = 1'b1;
    for (int i = 0; i < 200; i++) begin
      wr = ($urandom_range(0, 1) != 0);
      a  = 5'($urandom_range(0, (1<<AW) - 1));
      d  = $urandom;
      push(wr, a, d);
      if (wr) ref_mem[a] = d;
      else    exp_q.push_back('{ref_mem[a], a, 1'b0});
    end
    wait_rsp(exp_q.size());
    rsp_rand = 1'b0;
    for (int i = 0; i < exp_q.size(); i++) begin
      check($sformatf("rand_data_%0d", i), rsp_q[i].data, exp_q[i].data);
      check($sformatf("rand_addr_%0d", i), rsp_q[i].addr, exp_q[i].addr);
      check($sformatf("rand_err_%0d", i), rsp_q[i].err, 0);
    end
    check("no_wr_rd_overlap", n_both, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin : watchdog
    #300000;
    $display("FAIL global_timeout: simulation did not complete, compared %0d", n_cmp);
    $fatal(1);
  end

endmodule
